// File: rtl/multimode_shift_counter.sv
// N-bit Johnson / one-hot ring / LFSR sequence generator with load, direction, and self-correction.
// Latency: 1 clock from edge to q_out and flags. No backpressure: one step per enabled clock.
module multimode_shift_counter #(
  parameter int           N    = 4,
  parameter logic [N-1:0] TAPS = 4'b0011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d_in,
  input  logic [1:0]   mode,
  input  logic         dir,
  output logic [N-1:0] q_out,
  output logic         wrap,
  output logic         corr
);

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_LFSR    = 2'b10;

  logic [N-1:0] q_step;
  logic [N-1:0] seed;
  logic         legal;
  logic         shifting;
  logic [N-2:0] edges;
  logic         fb;

  // Each set bit marks a boundary between adjacent differing bits; a legal
  // Johnson state has at most one such boundary.
  assign edges = q_out[N-2:0] ^ q_out[N-1:1];
  assign fb    = ^(q_out & TAPS);

  always_comb begin
    q_step   = q_out;
    seed     = q_out;
    legal    = 1'b1;
    shifting = 1'b0;
    case (mode)
      MODE_JOHNSON: begin
        shifting = 1'b1;
        seed     = '0;
        legal    = (edges & (edges - (N-1)'(1))) == '0;
        q_step   = dir ? {q_out[N-2:0], ~q_out[N-1]} : {~q_out[0], q_out[N-1:1]};
      end
      MODE_RING: begin
        shifting = 1'b1;
        seed     = N'(1);
        legal    = (q_out != '0) && ((q_out & (q_out - N'(1))) == '0);
        q_step   = dir ? {q_out[N-2:0], q_out[N-1]} : {q_out[0], q_out[N-1:1]};
      end
      MODE_LFSR: begin
        shifting = 1'b1;
        seed     = N'(1);
        legal    = q_out != '0;
        q_step   = {fb, q_out[N-1:1]};
      end
      default: begin
        shifting = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_out <= '0;
      wrap  <= 1'b0;
      corr  <= 1'b0;
    end else if (load) begin
      q_out <= d_in;
      wrap  <= 1'b0;
      corr  <= 1'b0;
    end else if (en && !legal) begin
      q_out <= seed;
      wrap  <= 1'b0;
      corr  <= 1'b1;
    end else if (en) begin
      q_out <= q_step;
      wrap  <= shifting && (q_step == seed);
      corr  <= 1'b0;
    end else begin
      wrap  <= 1'b0;
      corr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_shift_counter.sv
// Directed-vector bench for multimode_shift_counter at N=4, default TAPS.
module tb_multimode_shift_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] d_in;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] q_out;
  logic       wrap;
  logic       corr;

  int total = 0;
  int bad   = 0;

  multimode_shift_counter dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .d_in  (d_in),
    .mode  (mode),
    .dir   (dir),
    .q_out (q_out),
    .wrap  (wrap),
    .corr  (corr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input logic ew, input logic ec);
    chk({tag, ".q"},    32'(q_out), 32'(eq));
    chk({tag, ".wrap"}, 32'(wrap),  32'(ew));
    chk({tag, ".corr"}, 32'(corr),  32'(ec));
  endtask

  logic [3:0] j_seq [8]  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
  logic [3:0] r_rt  [4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] r_lt  [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] l_seq [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101,
                             4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [15:0] seen;

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    d_in = 4'b0000;
    mode = 2'b00;
    dir  = 1'b0;
    #3;
    chk_state("reset", 4'b0000, 1'b0, 1'b0);
    step();
    rst = 1'b1;

    // Johnson right, full period
    mode = 2'b00; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_state($sformatf("john%0d", i), j_seq[i], i == 7, 1'b0);
    end
    en = 1'b0;
    step();
    chk_state("wrap_pulse_end", 4'b0000, 1'b0, 1'b0);

    // Ring right then left
    mode = 2'b01; load = 1'b1; d_in = 4'b0001;
    step();
    chk_state("ring_load", 4'b0001, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("ring_r%0d", i), r_rt[i], i == 3, 1'b0);
    end
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("ring_l%0d", i), r_lt[i], i == 3, 1'b0);
    end

    // LFSR full period
    en = 1'b0; mode = 2'b10; dir = 1'b0; load = 1'b1; d_in = 4'b0001;
    step();
    load = 1'b0; en = 1'b1;
    seen = 16'h0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen[q_out] = 1'b1;
      chk_state($sformatf("lfsr%0d", i), l_seq[i], i == 14, 1'b0);
    end
    chk("lfsr_distinct", 32'($countones(seen)), 32'd15);

    // Corrections
    en = 1'b0; mode = 2'b00; load = 1'b1; d_in = 4'b0101;
    step();
    chk_state("john_bad_load", 4'b0101, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    step();
    chk_state("john_corr", 4'b0000, 1'b0, 1'b1);
    step();
    chk_state("john_after_corr", 4'b1000, 1'b0, 1'b0);
    en = 1'b0; mode = 2'b01; load = 1'b1; d_in = 4'b0000;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk_state("ring_corr", 4'b0001, 1'b0, 1'b1);
    en = 1'b0; mode = 2'b10; load = 1'b1; d_in = 4'b0000;
    step();
    load = 1'b0; en = 1'b1;
    step();
    chk_state("lfsr_corr", 4'b0001, 1'b0, 1'b1);

    // Load priority, hold mode, disable
    mode = 2'b00; load = 1'b1; en = 1'b1; d_in = 4'b1010;
    step();
    chk_state("load_over_en", 4'b1010, 1'b0, 1'b0);
    load = 1'b0; mode = 2'b11;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_state($sformatf("hold%0d", i), 4'b1010, 1'b0, 1'b0);
    end
    en = 1'b0; mode = 2'b01;
    step();
    chk_state("en_low", 4'b1010, 1'b0, 1'b0);

    // Asynchronous reset mid-count
    mode = 2'b00; dir = 1'b0; load = 1'b1; d_in = 4'b0000;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_state("pre_reset", 4'b1110, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_state("async_reset", 4'b0000, 1'b0, 1'b0);
    step();
    chk_state("reset_held", 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_state("restart", 4'b1000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multimode_shift_counter.md
Name: multimode_shift_counter

Overview:
Parametrised N-bit shift-register counter with run-time selectable mode: Johnson (twisted ring), one-hot ring, or maximal-length LFSR. It adds shift direction, step enable, parallel load, self-correction of illegal states, and registered wrap/correction flags. It is a drop-in sequence generator for phase/timing generation in our sequential-circuits library.

Parameters:
N, 4, counter width; legal range N >= 2.
TAPS, 4'b0011, N-bit LFSR feedback mask; the feedback bit is the XOR-reduce of (q_out & TAPS). The default is maximal-length for N=4 (period 15).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-low reset.
en  input  1  step enable; one step per clock while high.
load  input  1  synchronous parallel load; has priority over en.
d_in  input  N  load value.
mode  input  2  00 Johnson, 01 ring, 10 LFSR, 11 hold.
dir  input  1  0 = shift right (toward bit 0), 1 = shift left; ignored in LFSR mode.
q_out  output  N  counter state, registered.
wrap  output  1  one-cycle pulse: the previous step entered the seed state.
corr  output  1  one-cycle pulse: the previous step was replaced by a correction.

Behaviour:
- Reset (rst low, asynchronous, any time including mid-count): q_out=0, wrap=0, corr=0. Normal operation resumes on the first clock edge after rst is high.
- Priority per rising edge: load > en > idle.
- load=1:
  - q_out <= d_in, unchecked.
  - wrap <= 0, corr <= 0.
- en=0 and load=0: q_out holds; wrap <= 0, corr <= 0.
- en=1, load=0, state legal for current mode (normal step):
  - Johnson right: {~q[0], q[N-1:1]}; Johnson left: {q[N-2:0], ~q[N-1]}.
  - Ring right: {q[0], q[N-1:1]}; ring left: {q[N-2:0], q[N-1]}.
  - LFSR: {fb, q[N-1:1]}, with fb = ^(q & TAPS). Always shifts right.
  - Hold mode (11): q_out unchanged, wrap=0, corr=0.
- Seed state per mode: Johnson 0; ring 1 (bit 0 set); LFSR 1.
- Legality per mode:
  - Johnson: the count of i in [0, N-2] with q[i] != q[i+1] is <= 1.
  - Ring: exactly one bit set.
  - LFSR: q != 0.
  - Hold: always legal.
- en=1, load=0, state illegal for current mode (correction):
  - q_out <= seed for that mode; no shift is performed.
  - corr <= 1, wrap <= 0.
  - Covers illegal d_in loads and mode changes that leave q_out illegal for the new mode.
- wrap <= 1 only after a normal step whose next q_out equals the seed; otherwise 0. Never set by load, correction or reset.
- Johnson period is 2N steps and ring period is N, in both directions. LFSR period depends on TAPS (2^N - 1 if maximal).
- Changes to mode or dir take effect on the next enabled step. No pipeline stage: q_out latency is 1 clock. Flags are registered alongside q_out.

Test Plan:
1. N=4, reset; Johnson, dir=0, en=1 for 8 clocks -> q_out 1000,1100,1110,1111,0111,0011,0001,0000. wrap=1 only after the 8th step, corr=0 throughout.
2. Ring, load d_in=0001, then en=1 with dir=0 -> 1000,0100,0010,0001, wrap after the 4th step. Switch dir=1 -> 0010,0100,1000,0001, wrap again after the 4th step.
3. LFSR, load 0001, en=1 for 15 clocks -> 1000,0100,0010,1001,1100,0110,1011,0101,1010,1101,1110,1111,0111,0011,0001. All 15 states are distinct and wrap fires only on the 15th step.
4. Johnson, load 0101, en=1 -> q_out=0000, corr=1, wrap=0; next step gives 1000 with corr=0. Ring with q_out=0000 and en=1 -> 0001, corr=1. LFSR with q_out=0000 and en=1 -> 0001, corr=1.
5. Simultaneous load=1, en=1 with d_in=1010 -> q_out=1010 with no shift. Hold mode with en=1 -> q_out stable, flags 0. en=0 in any mode -> q_out stable.
6. Johnson count at 1110: assert rst mid-cycle -> q_out=0, wrap=0, corr=0 immediately, without waiting for a clock edge. Release rst -> counting restarts at 1000.
